// File: rtl/stepper_phase_decoder.sv
// Receive-side decoder for a two-phase-on 4-phase stepper coil pattern.
// Recovers step events, direction and signed position; flags skips, illegal patterns and stalls.
module stepper_phase_decoder #(
  parameter int POS_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int STALL_W     = 16,
  parameter int STALL_LIMIT = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       coil_in,
  input  logic             clr_pos,
  output logic [POS_W-1:0] pos,
  output logic             step_pulse,
  output logic             dir_out,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic             stalled
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  logic [3:0]         sync_q [SYNC_STAGES];
  logic [3:0]         sync_d [SYNC_STAGES];
  logic [3:0]         cs;
  state_e             state_q, state_d;
  logic [1:0]         last_phase_q, last_phase_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic               err_q, err_d;
  logic [7:0]         err_count_q, err_count_d;
  logic [STALL_W-1:0] timer_q, timer_d;
  logic               stalled_q, stalled_d;
  logic [1:0]         phase;
  logic               phase_valid;
  logic               idle;
  logic [1:0]         delta;

  always_comb begin
    sync_d[0] = coil_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign cs = sync_q[SYNC_STAGES-1];

  always_comb begin
    phase       = '0;
    phase_valid = 1'b1;
    idle        = 1'b0;
    case (cs)
      4'b1001: phase = 2'd0;
      4'b1100: phase = 2'd1;
      4'b0110: phase = 2'd2;
      4'b0011: phase = 2'd3;
      4'b0000: begin
        phase_valid = 1'b0;
        idle        = 1'b1;
      end
      default: phase_valid = 1'b0;
    endcase
  end

  // Two-bit subtraction gives the forward phase distance modulo 4.
  assign delta = phase - last_phase_q;

  always_comb begin
    state_d      = state_q;
    last_phase_d = last_phase_q;
    pos_d        = pos_q;
    step_d       = 1'b0;
    dir_d        = dir_q;
    err_d        = 1'b0;
    err_count_d  = err_count_q;
    timer_d      = timer_q;
    stalled_d    = 1'b0;

    case (state_q)
      ST_UNLOCKED: begin
        if (phase_valid) begin
          state_d      = ST_LOCKED;
          last_phase_d = phase;
        end
      end
      ST_LOCKED: begin
        if (phase_valid) begin
          last_phase_d = phase;
          case (delta)
            2'd1: begin
              step_d = 1'b1;
              dir_d  = 1'b0;
              pos_d  = pos_q + POS_W'(1);
            end
            2'd3: begin
              step_d = 1'b1;
              dir_d  = 1'b1;
              pos_d  = pos_q - POS_W'(1);
            end
            2'd2:    err_d = 1'b1;
            default: ;
          endcase
        end else if (!idle) begin
          err_d   = 1'b1;
          state_d = ST_UNLOCKED;
        end
      end
    endcase

    if (err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    // Clear overrides the counters only; pulses and direction still reflect this cycle.
    if (clr_pos) begin
      pos_d       = '0;
      err_count_d = '0;
    end

    if ((state_d == ST_UNLOCKED) || step_d) begin
      timer_d = '0;
    end else if (timer_q != STALL_MAX) begin
      timer_d = timer_q + STALL_W'(1);
    end
    stalled_d = (timer_d == STALL_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      state_q      <= ST_UNLOCKED;
      last_phase_q <= '0;
      pos_q        <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
      timer_q      <= '0;
      stalled_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      state_q      <= state_d;
      last_phase_q <= last_phase_d;
      pos_q        <= pos_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
      timer_q      <= timer_d;
      stalled_q    <= stalled_d;
    end
  end

  assign pos        = pos_q;
  assign step_pulse = step_q;
  assign dir_out    = dir_q;
  assign locked     = (state_q == ST_LOCKED);
  assign err_pulse  = err_q;
  assign err_count  = err_count_q;
  assign stalled    = stalled_q;

endmodule
